bht_2bit: RTL and testbench
===========================

Name: bht_2bit

Overview:
- Branch history table of 2-bit saturating counters.
- Sits directly downstream of the execute-stage branch unit: consumes its resolved conditional-branch outcomes to train the counters.
- Serves taken/not-taken predictions to the frontend on lookup.
- Contains a self-clearing init FSM, a registered 1-cycle lookup path and saturating update logic.

Parameters:
- NR_ENTRIES, 1024, number of counters; power of two, minimum 4.
- VLEN, 39, virtual address width of lookup and update PCs.
- GHR_BITS, 8, global history length; used only when the optional feature is compiled in; must be ≤ log2(NR_ENTRIES).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_bp_i  in  1  one-cycle pulse; re-initialise the table.
- debug_mode_i  in  1  core in debug mode; suppresses training.
- lookup_valid_i  in  1  lookup request.
- lookup_pc_i  in  VLEN  PC to predict.
- predict_valid_o  out  1  prediction valid; 1 cycle after an accepted lookup.
- predict_taken_o  out  1  predicted direction (counter MSB).
- update_valid_i  in  1  resolved conditional branch from the branch unit.
- update_pc_i  in  VLEN  PC of the resolved branch.
- update_taken_i  in  1  actual outcome.
- init_busy_o  out  1  table initialising; lookups and updates are ignored.

Behaviour:
- Index: idx = pc[IDX_W:1], where IDX_W = log2(NR_ENTRIES). Bit 0 is dropped because PCs are halfword aligned (compressed instructions).
- States:
  - INIT: a counter init_idx writes 2'b01 (weakly not-taken) to entry init_idx every cycle.
  - IDLE: normal operation.
- Transitions:
  - INIT → IDLE in the cycle after init_idx == NR_ENTRIES-1 is written, so INIT lasts exactly NR_ENTRIES cycles.
  - IDLE → INIT on flush_bp_i.
- Reset (async, rst_ni low):
  - state = INIT, init_idx = 0.
  - predict_valid_o = 0, predict_taken_o = 0, init_busy_o = 1.
  - Array contents are not reset; the INIT sweep clears them.
- init_busy_o = 1 exactly while in INIT.
- flush_bp_i asserted while in INIT restarts the sweep: init_idx = 0 next cycle.
- Reset asserted mid-INIT restarts the sweep at 0.
- Lookup:
  - Accepted when lookup_valid_i is high and state is IDLE.
  - Next cycle: predict_valid_o = 1 and predict_taken_o = ctr[idx][1]; both are registered.
  - Otherwise predict_valid_o = 0 next cycle and predict_taken_o holds its last value.
- Update:
  - Accepted when update_valid_i is high, state is IDLE and debug_mode_i is low.
  - Taken: ctr = ctr + 1, saturating at 2'b11.
  - Not taken: ctr = ctr − 1, saturating at 2'b00.
  - Updates during INIT or debug mode are dropped silently; no stall, no backpressure.
- Read-during-write: a lookup and an update to the same index in the same cycle return the updated counter value (write-first bypass).
- Flush and lookup in the same cycle: the lookup is served (state is still IDLE that cycle); INIT starts next cycle.
- Flush and update in the same cycle: the update is written, then overwritten by the sweep.
- Aliasing between PCs that share an index is accepted; there is no tag.

Optional Feature:
- Macro: BHT_GSHARE_EN.
- When defined:
  - A GHR_BITS-wide global history register (ghr) is added.
  - Lookup and update index = pc[IDX_W:1] XOR zero-extended ghr.
  - On each accepted update: ghr = {ghr[GHR_BITS-2:0], update_taken_i}.
  - ghr is cleared by reset and on flush_bp_i.
  - The update index uses the ghr value before the shift.
  - A same-cycle lookup uses the pre-shift ghr.
- When not defined: no ghr, plain PC indexing, identical to the base behaviour above.

Test Plan:
- Release reset, hold lookups → init_busy_o high for exactly 1024 cycles. First lookup at pc 0x8000_0000 then returns predict_valid_o = 1, predict_taken_o = 0 one cycle later.
- Three taken updates at pc 0x100, then lookup 0x100 → predict_taken_o = 1; counter saturated at 11. One not-taken update → still taken (10). Two more not-taken → not taken (00).
- Update taken at 0x200 (counter 01→10) with a same-cycle lookup of 0x200 → predict_taken_o = 1 next cycle (bypass).
- Train 0x300 to 11, pulse flush_bp_i → init_busy_o high for 1024 cycles; afterwards lookup 0x300 → taken = 0. Second flush at sweep cycle 500 → busy lasts 1024 cycles from that flush.
- debug_mode_i = 1 with 4 taken updates at 0x400 → lookup 0x400 still not taken. Updates during INIT likewise have no effect.
- BHT_GSHARE_EN defined: pc 0x100 with alternating outcomes T,N,T,N… trains distinct entries; after 16 updates, lookups predict the alternation correctly. Without the macro the same sequence leaves a single counter oscillating between 01 and 10.

Source files
------------

// File: rtl/bht_2bit.sv
// bht_2bit: branch history table of 2-bit saturating counters.
// Optional gshare indexing is compiled in with `define BHT_GSHARE_EN.
module bht_2bit #(
    parameter int unsigned NR_ENTRIES = 1024,
    parameter int unsigned VLEN       = 39,
    parameter int unsigned GHR_BITS   = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_bp_i,
    input  logic            debug_mode_i,
    input  logic            lookup_valid_i,
    input  logic [VLEN-1:0] lookup_pc_i,
    output logic            predict_valid_o,
    output logic            predict_taken_o,
    input  logic            update_valid_i,
    input  logic [VLEN-1:0] update_pc_i,
    input  logic            update_taken_i,
    output logic            init_busy_o
);

    localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

    typedef enum logic {
        INIT,
        IDLE
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] init_idx_q, init_idx_d;
    logic [1:0]       ctr_q [NR_ENTRIES];

    logic [IDX_W-1:0] ghr_ext;
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] update_idx;
    logic             lookup_acc;
    logic             update_acc;
    logic [1:0]       upd_old;
    logic [1:0]       upd_new;
    logic             lookup_taken;

    // Bit 0 and the bits above the index never select an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc_i[VLEN-1:IDX_W+1], lookup_pc_i[0],
                              update_pc_i[VLEN-1:IDX_W+1], update_pc_i[0]};

`ifdef BHT_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q;

    assign ghr_ext = IDX_W'(ghr_q);

    // Global history: cleared on flush, shifted by each trained outcome.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ghr_q <= '0;
        end else if (flush_bp_i) begin
            ghr_q <= '0;
        end else if (update_acc) begin
            ghr_q <= {ghr_q[GHR_BITS-2:0], update_taken_i};
        end
    end
`else
    localparam int unsigned unused_ghr_bits = GHR_BITS;

    assign ghr_ext = '0;
`endif

    assign lookup_idx = lookup_pc_i[IDX_W:1] ^ ghr_ext;
    assign update_idx = update_pc_i[IDX_W:1] ^ ghr_ext;

    assign lookup_acc = lookup_valid_i && (state_q == IDLE);
    assign update_acc = update_valid_i && (state_q == IDLE) && !debug_mode_i;

    assign upd_old = ctr_q[update_idx];

    // Saturating increment/decrement of the trained counter.
    always_comb begin
        upd_new = upd_old;
        if (update_taken_i) begin
            if (upd_old != 2'b11) begin
                upd_new = upd_old + 2'd1;
            end
        end else begin
            if (upd_old != 2'b00) begin
                upd_new = upd_old - 2'd1;
            end
        end
    end

    // Write-first: a same-index update in this cycle is seen by the lookup.
    always_comb begin
        lookup_taken = ctr_q[lookup_idx][1];
        if (update_acc && (update_idx == lookup_idx)) begin
            lookup_taken = upd_new[1];
        end
    end

    // Next-state logic for the init sweep.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        unique case (state_q)
            INIT: begin
                if (flush_bp_i) begin
                    init_idx_d = '0;
                end else if (init_idx_q == LAST_IDX) begin
                    state_d    = IDLE;
                    init_idx_d = '0;
                end else begin
                    init_idx_d = init_idx_q + IDX_W'(1);
                end
            end
            IDLE: begin
                init_idx_d = '0;
                if (flush_bp_i) begin
                    state_d = INIT;
                end
            end
        endcase
    end

    // FSM state and sweep pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // Counter array: sweep writes weakly-not-taken, otherwise train.
    always_ff @(posedge clk_i) begin
        if (state_q == INIT) begin
            ctr_q[init_idx_q] <= 2'b01;
        end else if (update_acc) begin
            ctr_q[update_idx] <= upd_new;
        end
    end

    // Registered prediction; direction holds when no lookup is served.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            predict_valid_o <= 1'b0;
            predict_taken_o <= 1'b0;
        end else begin
            predict_valid_o <= lookup_acc;
            if (lookup_acc) begin
                predict_taken_o <= lookup_taken;
            end
        end
    end

    assign init_busy_o = (state_q == INIT);

endmodule

// File: tb/tb_bht_2bit.sv
// tb_bht_2bit: vector table plus scoreboard bench for bht_2bit.
// Expected predictions are queued when driven and checked one cycle later.
module tb_bht_2bit;

    localparam int NR = 1024;
    localparam int VL = 39;

`ifdef BHT_GSHARE_EN
    localparam logic [VL-1:0] ALT_PC = 39'h100;
    localparam logic [VL-1:0] CLR_PC = 39'h100;
    localparam bit ALT_T1 = 1'b1;
    localparam bit ALT_T2 = 1'b0;
`else
    localparam logic [VL-1:0] ALT_PC = 39'h700;
    localparam logic [VL-1:0] CLR_PC = 39'h300;
    localparam bit ALT_T1 = 1'b0;
    localparam bit ALT_T2 = 1'b1;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_bp_i = 1'b0;
    logic          debug_mode_i = 1'b0;
    logic          lookup_valid_i = 1'b0;
    logic [VL-1:0] lookup_pc_i = '0;
    logic          predict_valid_o;
    logic          predict_taken_o;
    logic          update_valid_i = 1'b0;
    logic [VL-1:0] update_pc_i = '0;
    logic          update_taken_i = 1'b0;
    logic          init_busy_o;

    typedef struct {
        bit            fl;
        bit            uv;
        logic [VL-1:0] upc;
        bit            ut;
        bit            dbg;
        bit            lv;
        logic [VL-1:0] lpc;
        bit            ev;
        bit            et;
        bit            ct;
    } vec_t;

    typedef struct {
        bit    v;
        bit    t;
        bit    ct;
        string name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bht_2bit dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_bp_i     (flush_bp_i),
        .debug_mode_i   (debug_mode_i),
        .lookup_valid_i (lookup_valid_i),
        .lookup_pc_i    (lookup_pc_i),
        .predict_valid_o(predict_valid_o),
        .predict_taken_o(predict_taken_o),
        .update_valid_i (update_valid_i),
        .update_pc_i    (update_pc_i),
        .update_taken_i (update_taken_i),
        .init_busy_o    (init_busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic vec_t mk(bit fl, bit uv, logic [VL-1:0] upc, bit ut,
                                bit dbg, bit lv, logic [VL-1:0] lpc,
                                bit ev, bit et, bit ct);
        vec_t r;
        r.fl = fl; r.uv = uv; r.upc = upc; r.ut = ut; r.dbg = dbg;
        r.lv = lv; r.lpc = lpc; r.ev = ev; r.et = et; r.ct = ct;
        return r;
    endfunction

    function automatic void add(bit uv, logic [VL-1:0] upc, bit ut, bit dbg,
                                bit lv, logic [VL-1:0] lpc,
                                bit ev, bit et, bit ct);
        tbl.push_back(mk(1'b0, uv, upc, ut, dbg, lv, lpc, ev, et, ct));
    endfunction

    task automatic idle_inputs();
        flush_bp_i     = 1'b0;
        debug_mode_i   = 1'b0;
        lookup_valid_i = 1'b0;
        lookup_pc_i    = '0;
        update_valid_i = 1'b0;
        update_pc_i    = '0;
        update_taken_i = 1'b0;
    endtask

    task automatic step(input vec_t vec, input string name);
        exp_t e;
        flush_bp_i     = vec.fl;
        update_valid_i = vec.uv;
        update_pc_i    = vec.upc;
        update_taken_i = vec.ut;
        debug_mode_i   = vec.dbg;
        lookup_valid_i = vec.lv;
        lookup_pc_i    = vec.lpc;
        sb.push_back('{v: vec.ev, t: vec.et, ct: vec.ct, name: name});
        tick();
        e = sb.pop_front();
        check({e.name, ".valid"}, 32'(predict_valid_o), 32'(e.v));
        if (e.ct) begin
            check({e.name, ".taken"}, 32'(predict_taken_o), 32'(e.t));
        end
        idle_inputs();
    endtask

    task automatic count_busy(output int n, output bit saw);
        n = 0;
        saw = 1'b0;
        while (init_busy_o && n < 3000) begin
            n++;
            tick();
            if (predict_valid_o) saw = 1'b1;
        end
        idle_inputs();
    endtask

    initial begin
        int n;
        bit saw;

        // Reset state
        #1;
        check("rst.valid", 32'(predict_valid_o), 32'd0);
        check("rst.taken", 32'(predict_taken_o), 32'd0);
        check("rst.busy", 32'(init_busy_o), 32'd1);
        repeat (3) tick();
        check("rst.busy_held", 32'(init_busy_o), 32'd1);
        rst_ni = 1'b1;
        count_busy(n, saw);
        check("init.cycles", 32'(n), 32'(NR));

        step(mk(0, 0, '0, 0, 0, 1, 39'h80000000, 1, 0, 1), "first_lookup");

        // Alternating outcomes on a single PC
        for (int i = 0; i < 16; i++) begin
            step(mk(0, 1, ALT_PC, (i % 2) == 0, 0, 0, '0, 0, 0, 0),
                 $sformatf("alt_upd%0d", i));
        end
        step(mk(0, 0, '0, 0, 0, 1, ALT_PC, 1, ALT_T1, 1), "alt_lookup1");
        step(mk(0, 1, ALT_PC, 1, 0, 0, '0, 0, 0, 0), "alt_upd16");
        step(mk(0, 0, '0, 0, 0, 1, ALT_PC, 1, ALT_T2, 1), "alt_lookup2");

`ifndef BHT_GSHARE_EN
        // Saturation, hold, bypass, alias, debug suppression
        add(1, 39'h100, 1, 0, 0, '0, 0, 0, 0);
        add(1, 39'h100, 1, 0, 0, '0, 0, 0, 0);
        add(1, 39'h100, 1, 0, 0, '0, 0, 0, 0);
        add(0, '0, 0, 0, 1, 39'h100, 1, 1, 1);
        add(0, '0, 0, 0, 0, '0, 0, 1, 1);
        add(1, 39'h100, 0, 0, 0, '0, 0, 0, 0);
        add(0, '0, 0, 0, 1, 39'h100, 1, 1, 1);
        add(1, 39'h100, 0, 0, 0, '0, 0, 0, 0);
        add(0, '0, 0, 0, 1, 39'h100, 1, 0, 1);
        add(1, 39'h100, 0, 0, 0, '0, 0, 0, 0);
        add(0, '0, 0, 0, 1, 39'h100, 1, 0, 1);
        add(1, 39'h100, 0, 0, 0, '0, 0, 0, 0);
        add(1, 39'h100, 1, 0, 0, '0, 0, 0, 0);
        add(0, '0, 0, 0, 1, 39'h100, 1, 0, 1);
        add(1, 39'h100, 1, 0, 0, '0, 0, 0, 0);
        add(0, '0, 0, 0, 1, 39'h100, 1, 1, 1);
        add(1, 39'h200, 1, 0, 1, 39'h200, 1, 1, 1);
        add(0, '0, 0, 0, 1, 39'ha00, 1, 1, 1);
        add(0, '0, 0, 0, 1, 39'h201, 1, 1, 1);
        add(1, 39'h200, 0, 0, 1, 39'h200, 1, 0, 1);
        add(0, '0, 0, 0, 1, 39'h200, 1, 0, 1);
        for (int i = 0; i < 4; i++) add(1, 39'h400, 1, 1, 0, '0, 0, 0, 0);
        add(0, '0, 0, 1, 1, 39'h400, 1, 0, 1);
        add(0, '0, 0, 0, 1, 39'h400, 1, 0, 1);
        add(1, 39'h300, 1, 0, 0, '0, 0, 0, 0);
        add(1, 39'h300, 1, 0, 0, '0, 0, 0, 0);
        add(0, '0, 0, 0, 1, 39'h300, 1, 1, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end
`endif

        // Flush with same-cycle lookup and update; traffic during sweep
        step(mk(1, 1, 39'h600, 1, 0, 1, 39'h80000000, 1, 0, 1), "flush_lu");
        update_valid_i = 1'b1;
        update_pc_i    = 39'h500;
        update_taken_i = 1'b1;
        lookup_valid_i = 1'b1;
        lookup_pc_i    = 39'h500;
        count_busy(n, saw);
        check("flush.cycles", 32'(n), 32'(NR));
        check("flush.no_predict", 32'(saw), 32'd0);
        step(mk(0, 0, '0, 0, 0, 1, CLR_PC, 1, 0, 1), "flush.cleared");
        step(mk(0, 0, '0, 0, 0, 1, 39'h600, 1, 0, 1), "flush.upd_lost");
        step(mk(0, 0, '0, 0, 0, 1, 39'h500, 1, 0, 1), "init.upd_drop");

        // Second flush in the middle of the sweep
        step(mk(1, 0, '0, 0, 0, 0, '0, 0, 0, 0), "flush2a");
        repeat (499) tick();
        check("flush2.busy_mid", 32'(init_busy_o), 32'd1);
        step(mk(1, 0, '0, 0, 0, 1, 39'h100, 0, 0, 0), "flush2b");
        count_busy(n, saw);
        check("flush2.cycles", 32'(n), 32'(NR));

        // Reset in the middle of the sweep
        step(mk(1, 0, '0, 0, 0, 0, '0, 0, 0, 0), "flush3");
        repeat (100) tick();
        rst_ni = 1'b0;
        #1;
        check("rst2.busy", 32'(init_busy_o), 32'd1);
        check("rst2.valid", 32'(predict_valid_o), 32'd0);
        check("rst2.taken", 32'(predict_taken_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        count_busy(n, saw);
        check("rst2.cycles", 32'(n), 32'(NR));
        step(mk(0, 0, '0, 0, 0, 1, 39'h80000000, 1, 0, 1), "rst2.lookup");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
